// File: rtl/caliptra_fpga_itrng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : caliptra_fpga_itrng_pkg
// Description : Shared types and constants for the FPGA ITRNG nibble feeder:
//               the feeder FSM state encoding, the nibble width and the
//               default FIFO read-data timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package caliptra_fpga_itrng_pkg;

  // Width of one entropy nibble as seen by Caliptra and the ITRNG FIFO.
  localparam int unsigned c_nibble_w = 4;

  // Default number of cycles to wait for FIFO read data after a pop.
  localparam int unsigned c_rd_timeout_default = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    WAIT_DATA = 3'd2,
    PRESENT   = 3'd3,
    HOLDOFF   = 3'd4
  } feeder_state_e;

endpackage : caliptra_fpga_itrng_pkg
`default_nettype wire

// File: rtl/itrng_nibble_feeder.sv
`default_nettype none
// ============================================================================
// Module      : itrng_nibble_feeder
// Description : Paces entropy nibbles from the ITRNG FIFO to Caliptra. Each
//               request pops one nibble, waits for FIFO read data, presents it
//               for one cycle, then holds off for 'divisor' extra cycles.
//               Requests against an empty FIFO are refused and counted.
// Ports       :
//   core_clk        in   clock, all state on rising edge
//   cptra_rst_b     in   asynchronous active-low reset
//   etrng_req       in   level request for entropy
//   divisor         in   idle cycles after each delivery/refusal
//   soft_clr        in   synchronous abort/clear
//   fifo_empty      in   FIFO empty flag
//   fifo_dout       in   FIFO read data, qualified by fifo_valid
//   fifo_valid      in   FIFO read-data valid
//   fifo_rd_en      out  single-cycle FIFO pop strobe
//   itrng_data      out  nibble to Caliptra (held between deliveries)
//   itrng_valid     out  single-cycle qualifier for itrng_data
//   underrun_count  out  saturating count of refused requests
//   rd_timeout_err  out  sticky FIFO read timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module itrng_nibble_feeder
  import caliptra_fpga_itrng_pkg::*;
#(
  parameter int unsigned DIV_W      = 32,
  parameter int unsigned UCNT_W     = 16,
  parameter int unsigned RD_TIMEOUT = c_rd_timeout_default
) (
  input  logic                  core_clk,
  input  logic                  cptra_rst_b,
  input  logic                  etrng_req,
  input  logic [DIV_W-1:0]      divisor,
  input  logic                  soft_clr,
  input  logic                  fifo_empty,
  input  logic [c_nibble_w-1:0] fifo_dout,
  input  logic                  fifo_valid,
  output logic                  fifo_rd_en,
  output logic [c_nibble_w-1:0] itrng_data,
  output logic                  itrng_valid,
  output logic [UCNT_W-1:0]     underrun_count,
  output logic                  rd_timeout_err
);

  // The wait counter only needs to reach RD_TIMEOUT-1: the cycle in which it
  // holds that value without fifo_valid is the last allowed WAIT_DATA cycle.
  localparam int unsigned c_wait_w = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(RD_TIMEOUT - 1);

  feeder_state_e         r_state;
  feeder_state_e         w_state_nxt;
  logic [DIV_W-1:0]      r_hold_cnt;
  logic [DIV_W-1:0]      w_hold_nxt;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic [c_wait_w-1:0]   w_wait_nxt;
  logic [c_nibble_w-1:0] r_data;
  logic [c_nibble_w-1:0] w_data_nxt;
  logic [UCNT_W-1:0]     r_ucnt;
  logic [UCNT_W-1:0]     w_ucnt_nxt;
  logic                  r_err;
  logic                  w_err_nxt;

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_wait_cnt <= '0;
      r_data     <= '0;
      r_ucnt     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_data     <= w_data_nxt;
      r_ucnt     <= w_ucnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_data_nxt  = r_data;
    w_ucnt_nxt  = r_ucnt;
    w_err_nxt   = r_err;

    if (soft_clr) begin
      // Abort whatever is in flight; the captured nibble is left as-is so
      // itrng_data keeps showing the last delivered value.
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
      w_wait_nxt  = '0;
      w_ucnt_nxt  = '0;
      w_err_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (etrng_req) begin
            if (!fifo_empty) begin
              w_state_nxt = POP;
            end else begin
              // Refusal is followed by a holdoff, so a sustained request is
              // counted once per holdoff period rather than every cycle.
              if (r_ucnt != {UCNT_W{1'b1}}) begin
                w_ucnt_nxt = r_ucnt + UCNT_W'(1);
              end
              w_hold_nxt  = divisor;
              w_state_nxt = HOLDOFF;
            end
          end
        end
        POP: begin
          w_wait_nxt  = '0;
          w_state_nxt = WAIT_DATA;
        end
        WAIT_DATA: begin
          if (fifo_valid) begin
            w_data_nxt  = fifo_dout;
            w_state_nxt = PRESENT;
          end else if (r_wait_cnt == c_wait_last) begin
            w_err_nxt   = 1'b1;
            w_wait_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_wait_nxt = r_wait_cnt + c_wait_w'(1);
          end
        end
        PRESENT: begin
          w_hold_nxt  = divisor;
          w_state_nxt = HOLDOFF;
        end
        HOLDOFF: begin
          // A counter loaded with N gives N+1 HOLDOFF cycles, so divisor=0
          // leaves HOLDOFF the cycle after entry.
          if (r_hold_cnt == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_hold_nxt = r_hold_cnt - DIV_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so reset clears them immediately.
  assign fifo_rd_en     = (r_state == POP);
  assign itrng_valid    = (r_state == PRESENT);
  assign itrng_data     = r_data;
  assign underrun_count = r_ucnt;
  assign rd_timeout_err = r_err;

endmodule : itrng_nibble_feeder
`default_nettype wire

// File: tb/tb_itrng_nibble_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_itrng_nibble_feeder
// Description : Self-checking bench for itrng_nibble_feeder. A FIFO model
//               answers pops one cycle later; an event-level model predicts
//               delivery cycles, nibbles, pops and underrun counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itrng_nibble_feeder;

  localparam int UW   = 4;
  localparam int UMAX = (1 << UW) - 1;

  logic          core_clk    = 1'b0;
  logic          cptra_rst_b = 1'b0;
  logic          etrng_req   = 1'b0;
  logic [31:0]   divisor     = '0;
  logic          soft_clr    = 1'b0;
  logic          fifo_empty  = 1'b1;
  logic [3:0]    fifo_dout   = '0;
  logic          fifo_valid  = 1'b0;
  logic          fifo_rd_en;
  logic [3:0]    itrng_data;
  logic          itrng_valid;
  logic [UW-1:0] underrun_count;
  logic          rd_timeout_err;

  itrng_nibble_feeder #(
    .DIV_W      (32),
    .UCNT_W     (UW),
    .RD_TIMEOUT (4)
  ) dut (
    .core_clk       (core_clk),
    .cptra_rst_b    (cptra_rst_b),
    .etrng_req      (etrng_req),
    .divisor        (divisor),
    .soft_clr       (soft_clr),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
    .fifo_valid     (fifo_valid),
    .fifo_rd_en     (fifo_rd_en),
    .itrng_data     (itrng_data),
    .itrng_valid    (itrng_valid),
    .underrun_count (underrun_count),
    .rd_timeout_err (rd_timeout_err)
  );

  always #5 core_clk = ~core_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         rd_cnt  = 0;
  bit         suppress_valid = 1'b0;
  logic [3:0] q[$];
  logic [3:0] load_q[$];
  int         obs_cyc[$];
  logic [3:0] obs_dat[$];
  int         exp_cyc[$];
  logic [3:0] exp_dat[$];
  int         und_m  = 0;
  logic [3:0] last_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: FIFO answers a pop one cycle later, outputs are
  // sampled on the falling edge.
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    @(posedge core_clk);
    #1;
    fifo_valid = 1'b0;
    if (rd && q.size() > 0) begin
      fifo_dout  = q.pop_front();
      fifo_valid = !suppress_valid;
    end
    fifo_empty = (q.size() == 0);
    cyc++;
    @(negedge core_clk);
    if (itrng_valid) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(itrng_data);
    end
    if (fifo_rd_en) rd_cnt++;
  endtask

  task automatic clear_obs();
    obs_cyc.delete();
    obs_dat.delete();
    exp_cyc.delete();
    exp_dat.delete();
    rd_cnt = 0;
  endtask

  // Hold etrng_req for n_req cycles with load_q preloaded in the FIFO.
  // Each decision taken while the request is high either delivers a nibble
  // 3 cycles later and decides again 5+d cycles later, or is refused and
  // decides again 2+d cycles later.
  task automatic run_phase(input string tag, input int d, input int n_req);
    int t;
    int idx;
    int c0;
    divisor = d;
    q.delete();
    foreach (load_q[i]) q.push_back(load_q[i]);
    fifo_empty = (q.size() == 0);
    tick();
    tick();
    clear_obs();
    c0  = cyc;
    t   = c0;
    idx = 0;
    while (t < c0 + n_req) begin
      if (idx < load_q.size()) begin
        exp_cyc.push_back(t + 3);
        exp_dat.push_back(load_q[idx]);
        last_m = load_q[idx];
        idx++;
        t += 5 + d;
      end else begin
        if (und_m < UMAX) und_m++;
        t += 2 + d;
      end
    end
    etrng_req = 1'b1;
    repeat (n_req) tick();
    etrng_req = 1'b0;
    repeat (20 + d) tick();
    check({tag, "_pulses"}, obs_cyc.size(), exp_cyc.size());
    foreach (exp_cyc[i]) begin
      if (i < obs_cyc.size()) begin
        check($sformatf("%s_cyc%0d", tag, i), obs_cyc[i] - c0, exp_cyc[i] - c0);
        check($sformatf("%s_dat%0d", tag, i), obs_dat[i], exp_dat[i]);
      end
    end
    check({tag, "_pops"}, rd_cnt, idx);
    check({tag, "_underrun"}, underrun_count, und_m);
    check({tag, "_data_hold"}, itrng_data, last_m);
    check({tag, "_no_err"}, rd_timeout_err, 0);
    q.delete();
    fifo_empty = 1'b1;
  endtask

  initial begin
    int c0;

    // Reset state
    repeat (2) @(negedge core_clk);
    cptra_rst_b = 1'b1;
    @(negedge core_clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", itrng_valid, 0);
    check("rst_data", itrng_data, 0);
    check("rst_underrun", underrun_count, 0);
    check("rst_err", rd_timeout_err, 0);

    // Three nibbles, back-to-back pacing, then refusals
    load_q = '{4'h3, 4'hA, 4'h5};
    run_phase("div0", 0, 25);

    // Divisor 10 with a FIFO that never runs dry
    load_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
    run_phase("div10", 10, 100);

    // Request dropped right after the pop: nibble still delivered
    load_q = '{4'hE, 4'h6};
    run_phase("req_drop", 0, 2);

    // Stray fifo_valid outside WAIT_DATA is ignored
    clear_obs();
    fifo_dout  = 4'hF;
    fifo_valid = 1'b1;
    tick();
    tick();
    check("stray_no_valid", obs_cyc.size(), 0);
    check("stray_data_hold", itrng_data, last_m);

    // Read timeout, then soft_clr
    q.delete();
    q.push_back(4'h9);
    fifo_empty     = 1'b0;
    divisor        = 0;
    suppress_valid = 1'b1;
    tick();
    tick();
    clear_obs();
    c0 = cyc;
    etrng_req = 1'b1;
    tick();
    etrng_req = 1'b0;
    while (cyc < c0 + 5) tick();
    check("to_err_before", rd_timeout_err, 0);
    tick();
    check("to_err_set", rd_timeout_err, 1);
    repeat (4) tick();
    check("to_no_valid", obs_cyc.size(), 0);
    check("to_pops", rd_cnt, 1);
    check("to_err_sticky", rd_timeout_err, 1);
    suppress_valid = 1'b0;
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    und_m = 0;
    check("sc_err", rd_timeout_err, 0);
    check("sc_underrun", underrun_count, 0);
    check("sc_data_hold", itrng_data, last_m);

    // Empty FIFO, divisor 3: 20 refusals saturate a 4-bit counter
    load_q.delete();
    run_phase("empty_sat", 3, 100);

    // Reset during WAIT_DATA discards the nibble
    q.delete();
    q.push_back(4'h7);
    fifo_empty = 1'b0;
    divisor    = 0;
    tick();
    tick();
    clear_obs();
    etrng_req = 1'b1;
    tick();
    tick();
    #1;
    cptra_rst_b = 1'b0;
    etrng_req   = 1'b0;
    #1;
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_valid", itrng_valid, 0);
    check("arst_data", itrng_data, 0);
    check("arst_underrun", underrun_count, 0);
    check("arst_err", rd_timeout_err, 0);
    repeat (3) tick();
    cptra_rst_b = 1'b1;
    repeat (10) tick();
    und_m  = 0;
    last_m = '0;
    check("arst_no_valid", obs_cyc.size(), 0);
    check("arst_pops_after", rd_cnt, 1);
    check("arst_data_after", itrng_data, 0);
    q.delete();
    fifo_empty = 1'b1;

    // Randomized phases
    for (int p = 0; p < 6; p++) begin
      int n_items;
      load_q.delete();
      n_items = $urandom_range(0, 6);
      for (int k = 0; k < n_items; k++) load_q.push_back(4'($urandom_range(0, 15)));
      run_phase($sformatf("rnd%0d", p), $urandom_range(0, 7), $urandom_range(1, 60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_itrng_nibble_feeder
`default_nettype wire

// File: doc/itrng_nibble_feeder.md
ITRNG_NIBBLE_FEEDER -- requirements
Module: itrng_nibble_feeder

Interface
REQ-001 Parameter DIV_W, default 32, width of the pacing divisor and its down-counter.
REQ-002 Parameter UCNT_W, default 16, width of the saturating underrun counter.
REQ-003 Parameter RD_TIMEOUT, default 4, maximum cycles to wait for fifo_valid after a read strobe.
REQ-004 core_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 cptra_rst_b  in  1  reset, asynchronous assert, active-low.
REQ-006 etrng_req  in  1  Caliptra level request for entropy nibbles.
REQ-007 divisor  in  DIV_W  idle cycles inserted after each delivered nibble; software register value.
REQ-008 soft_clr  in  1  synchronous abort/clear, driven by the ITRNG FIFO reset control bit.
REQ-009 fifo_empty  in  1  ITRNG FIFO empty flag.
REQ-010 fifo_dout  in  4  ITRNG FIFO read data, qualified by fifo_valid.
REQ-011 fifo_valid  in  1  FIFO read-data valid, nominally 1 cycle after fifo_rd_en.
REQ-012 fifo_rd_en  out  1  single-cycle FIFO pop strobe.
REQ-013 itrng_data  out  4  nibble presented to Caliptra.
REQ-014 itrng_valid  out  1  single-cycle qualifier for itrng_data.
REQ-015 underrun_count  out  UCNT_W  saturating count of requests refused due to empty FIFO.
REQ-016 rd_timeout_err  out  1  sticky flag: fifo_valid not seen within RD_TIMEOUT cycles.

Function
REQ-017 FSM states SHALL be IDLE, POP, WAIT_DATA, PRESENT, HOLDOFF.
REQ-018 IDLE: etrng_req=1 and fifo_empty=0 -> POP; etrng_req=1 and fifo_empty=1 -> underrun_count+1 (saturate at all-ones), load holdoff counter with divisor, -> HOLDOFF; etrng_req=0 -> stay.
REQ-019 POP: fifo_rd_en=1 for exactly this cycle, -> WAIT_DATA with wait counter cleared; fifo_rd_en SHALL be 0 in every other state.
REQ-020 WAIT_DATA: fifo_valid=1 -> capture fifo_dout into data register, -> PRESENT; otherwise increment wait counter; on reaching RD_TIMEOUT set rd_timeout_err, -> IDLE with no nibble delivered.
REQ-021 PRESENT: itrng_valid=1 for exactly one cycle with itrng_data = captured nibble; load holdoff counter with divisor, -> HOLDOFF.
REQ-022 HOLDOFF: decrement counter each cycle; counter==0 -> IDLE; divisor=0 SHALL give zero extra cycles (HOLDOFF exits the cycle after entry).
REQ-023 Minimum nibble spacing SHALL be 5 + divisor cycles (IDLE, POP, WAIT_DATA with 1-cycle FIFO latency, PRESENT, HOLDOFF).
REQ-024 etrng_req falling after POP SHALL NOT abort; the popped nibble is still presented, then HOLDOFF, then IDLE.
REQ-025 divisor changes SHALL take effect only at the next counter load.
REQ-026 itrng_data SHALL hold its last value when itrng_valid=0.
REQ-027 soft_clr=1 SHALL, next edge, force IDLE, clear holdoff/wait counters, underrun_count and rd_timeout_err, deassert fifo_rd_en and itrng_valid; soft_clr has priority over all transitions.
REQ-028 A fifo_valid arriving in any state other than WAIT_DATA SHALL be ignored.
REQ-029 Underrun refusal counts once per HOLDOFF period, not every cycle of a sustained request.

Reset
REQ-030 cptra_rst_b low SHALL immediately force IDLE, fifo_rd_en=0, itrng_valid=0, itrng_data=0, underrun_count=0, rd_timeout_err=0, all counters 0, independent of core_clk.
REQ-031 Reset asserted mid-sequence (POP/WAIT_DATA/PRESENT) SHALL discard the nibble; no itrng_valid pulse after release until a new request.

Structure
REQ-032 FSM state enum, RD_TIMEOUT default and nibble width constant SHALL live in shared package caliptra_fpga_itrng_pkg.
REQ-033 Single module, no sub-modules; a saturating counter is inlined.

Verification
REQ-034 divisor=0, FIFO preloaded 4'h3,4'hA,4'h5, etrng_req held -> itrng_valid pulses 5 cycles apart carrying 3,A,5, then underrun_count increments.
REQ-035 divisor=10, FIFO full, etrng_req held 100 cycles -> itrng_valid spacing exactly 15 cycles, fifo_rd_en pulses equal itrng_valid pulses.
REQ-036 FIFO empty, etrng_req held, divisor=3 -> underrun_count increments every 5 cycles, saturates at 16'hFFFF, no fifo_rd_en.
REQ-037 fifo_valid suppressed after POP -> rd_timeout_err=1 after 4 cycles, FSM back in IDLE, no itrng_valid; soft_clr clears flag.
REQ-038 etrng_req dropped the cycle after POP -> one itrng_valid pulse still delivered, then idle.
REQ-039 cptra_rst_b asserted in WAIT_DATA, released 3 cycles later with etrng_req=0 -> all outputs 0, no itrng_valid pulse.
